// File: rtl/pipe_flush_ctrl.sv
// Pipeline flush/redirect controller: arbitrates interrupts, exceptions, mispredicts and mret
// into a registered flush mask plus fetch redirect. Optional perf counters via PIPE_FLUSH_PERF_CNT_EN.
module pipe_flush_ctrl #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NIRQ       = 3,
    parameter int unsigned MRET_STAGE = 1,
    parameter int unsigned FLUSH_HOLD = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_STAGES-1:0]      stage_exc_valid_i,
    input  logic [NUM_STAGES*5-1:0]    stage_cause_i,
    input  logic [NUM_STAGES*XLEN-1:0] stage_pc_i,
    input  logic                       mret_i,
    input  logic [XLEN-1:0]            mepc_i,
    input  logic [XLEN-1:0]            mtvec_i,
    input  logic                       mispredict_i,
    input  logic [XLEN-1:0]            mispredict_target_i,
    input  logic [NIRQ-1:0]            irq_i,
    input  logic                       irq_en_i,
    output logic [NUM_STAGES-1:0]      flush_o,
    output logic                       redirect_valid_o,
    output logic [XLEN-1:0]            redirect_pc_o,
    input  logic                       redirect_ready_i,
    output logic                       trap_valid_o,
    output logic [5:0]                 trap_cause_o,
    output logic [XLEN-1:0]            trap_pc_o,
`ifdef PIPE_FLUSH_PERF_CNT_EN
    output logic [31:0]                perf_trap_cnt_o,
    output logic [31:0]                perf_mispred_cnt_o,
`endif
    output logic                       busy_o
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_INIT = (FLUSH_HOLD > 0) ? CNT_W'(FLUSH_HOLD - 1) : '0;
    localparam logic [NUM_STAGES-1:0] ALL_ONES     = '1;
    localparam logic [NUM_STAGES-1:0] MISPRED_MASK = ALL_ONES >> 1;
    localparam logic [NUM_STAGES-1:0] MRET_MASK    = ALL_ONES >> (NUM_STAGES - 1 - MRET_STAGE);

    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;

    logic                  irq_hit;
    logic                  exc_hit;
    logic [4:0]            irq_code;
    logic [4:0]            exc_code;
    logic [XLEN-1:0]       exc_pc;
    logic [NUM_STAGES-1:0] exc_mask;
    logic                  ev_valid;
    logic                  ev_trap;
    logic [NUM_STAGES-1:0] ev_flush;
    logic [XLEN-1:0]       ev_pc;
    logic [5:0]            ev_cause;
    logic [XLEN-1:0]       ev_trap_pc;

    // Event decode: highest irq index and oldest excepting stage win their class
    always_comb begin
        irq_hit  = irq_en_i & (|irq_i);
        irq_code = '0;
        for (int i = 0; i < int'(NIRQ); i++) begin
            if (irq_i[i]) irq_code = 5'(4 * i + 3);
        end
        exc_hit  = |stage_exc_valid_i;
        exc_code = '0;
        exc_pc   = '0;
        exc_mask = '0;
        for (int k = 0; k < int'(NUM_STAGES); k++) begin
            if (stage_exc_valid_i[k]) begin
                exc_code = stage_cause_i[k*5 +: 5];
                exc_pc   = stage_pc_i[k*XLEN +: XLEN];
                exc_mask = ALL_ONES >> (int'(NUM_STAGES) - 1 - k);
            end
        end

        ev_valid   = 1'b1;
        ev_trap    = 1'b0;
        ev_flush   = '0;
        ev_pc      = '0;
        ev_cause   = '0;
        ev_trap_pc = '0;
        if (irq_hit) begin
            ev_trap    = 1'b1;
            ev_flush   = ALL_ONES;
            ev_pc      = mtvec_i;
            ev_cause   = {1'b1, irq_code};
            ev_trap_pc = stage_pc_i[(NUM_STAGES-1)*XLEN +: XLEN];
        end else if (exc_hit) begin
            ev_trap    = 1'b1;
            ev_flush   = exc_mask;
            ev_pc      = mtvec_i;
            ev_cause   = {1'b0, exc_code};
            ev_trap_pc = exc_pc;
        end else if (mispredict_i) begin
            ev_flush = MISPRED_MASK;
            ev_pc    = mispredict_target_i;
        end else if (mret_i) begin
            ev_flush = MRET_MASK;
            ev_pc    = mepc_i;
        end else begin
            ev_valid = 1'b0;
        end
    end

    // Controller FSM with registered outputs; events only sampled in IDLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            flush_o          <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            trap_valid_o     <= 1'b0;
            trap_cause_o     <= '0;
            trap_pc_o        <= '0;
            busy_o           <= 1'b0;
        end else begin
            trap_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_valid) begin
                        state            <= REDIRECT;
                        busy_o           <= 1'b1;
                        flush_o          <= ev_flush;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= ev_pc;
                        trap_valid_o     <= ev_trap;
                        if (ev_trap) begin
                            trap_cause_o <= ev_cause;
                            trap_pc_o    <= ev_trap_pc;
                        end
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        redirect_valid_o <= 1'b0;
                        redirect_pc_o    <= '0;
                        hold_cnt         <= HOLD_INIT;
                        if (FLUSH_HOLD == 0) begin
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                            flush_o <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (hold_cnt == '0) begin
                        state   <= IDLE;
                        busy_o  <= 1'b0;
                        flush_o <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_FLUSH_PERF_CNT_EN
    logic ev_mispred;
    assign ev_mispred = ~irq_hit & ~exc_hit & mispredict_i;

    // Count events only when accepted in IDLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_trap_cnt_o    <= '0;
            perf_mispred_cnt_o <= '0;
        end else if (state == IDLE) begin
            if (ev_trap)    perf_trap_cnt_o    <= perf_trap_cnt_o + 32'd1;
            if (ev_mispred) perf_mispred_cnt_o <= perf_mispred_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Scoreboard bench for pipe_flush_ctrl; perf counters checked when PIPE_FLUSH_PERF_CNT_EN is defined.
module tb_pipe_flush_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   stage_exc_valid = '0;
    logic [19:0]  stage_cause = {5'd5, 5'd2, 5'd7, 5'd4};
    logic [127:0] stage_pc = {32'h400, 32'h100, 32'h20, 32'h10};
    logic         mret = 1'b0;
    logic [31:0]  mepc = 32'h3000;
    logic [31:0]  mtvec = 32'h80;
    logic         mispredict = 1'b0;
    logic [31:0]  mispredict_target = 32'h2000;
    logic [2:0]   irq = '0;
    logic         irq_en = 1'b0;
    logic [3:0]   flush;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         redirect_ready = 1'b0;
    logic         trap_valid;
    logic [5:0]   trap_cause;
    logic [31:0]  trap_pc;
    logic         busy;
`ifdef PIPE_FLUSH_PERF_CNT_EN
    logic [31:0]  perf_trap_cnt;
    logic [31:0]  perf_mispred_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_traps = 0;
    int exp_mis = 0;

    typedef struct packed {
        logic [3:0]  flush;
        logic [31:0] rpc;
        logic        trap;
        logic [5:0]  cause;
        logic [31:0] tpc;
    } exp_t;

    typedef struct {
        logic [3:0] exc;
        logic [2:0] irq;
        logic       en;
        logic       mis;
        logic       mret;
        int         delay;
        exp_t       exp;
    } case_t;

    exp_t sb[$];

    pipe_flush_ctrl dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .stage_exc_valid_i   (stage_exc_valid),
        .stage_cause_i       (stage_cause),
        .stage_pc_i          (stage_pc),
        .mret_i              (mret),
        .mepc_i              (mepc),
        .mtvec_i             (mtvec),
        .mispredict_i        (mispredict),
        .mispredict_target_i (mispredict_target),
        .irq_i               (irq),
        .irq_en_i            (irq_en),
        .flush_o             (flush),
        .redirect_valid_o    (redirect_valid),
        .redirect_pc_o       (redirect_pc),
        .redirect_ready_i    (redirect_ready),
        .trap_valid_o        (trap_valid),
        .trap_cause_o        (trap_cause),
        .trap_pc_o           (trap_pc),
`ifdef PIPE_FLUSH_PERF_CNT_EN
        .perf_trap_cnt_o     (perf_trap_cnt),
        .perf_mispred_cnt_o  (perf_mispred_cnt),
`endif
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    task automatic set_ev(input logic [3:0] exc, input logic [2:0] irq_v, input logic en,
                          input logic mis, input logic mr);
        stage_exc_valid = exc;
        irq             = irq_v;
        irq_en          = en;
        mispredict      = mis;
        mret            = mr;
    endtask

    task automatic push_exp(input exp_t e, input logic is_mis);
        sb.push_back(e);
        if (e.trap) exp_traps++;
        if (is_mis) exp_mis++;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        set_ev(4'b0100, 3'b000, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({flush, redirect_valid, redirect_pc, trap_valid, trap_cause, trap_pc, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got flush=%b rv=%b rpc=%h tv=%b cause=%h tpc=%h busy=%b want all 0",
                     flush, redirect_valid, redirect_pc, trap_valid, trap_cause, trap_pc, busy);
        end
        exp_traps = 0;
        exp_mis   = 0;
        // Mispredict held through reset must be taken in the first cycle rst is low
        rst = 1'b0;
        set_ev(4'b0000, 3'b000, 1'b0, 1'b1, 1'b0);
        push_exp('{4'b0111, 32'h2000, 1'b0, 6'h00, 32'h0}, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({redirect_valid, flush, redirect_pc, trap_valid, busy} !== {1'b1, e.flush, e.rpc, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release_resp got rv=%b flush=%b rpc=%h tv=%b busy=%b want rv=1 flush=%b rpc=%h tv=0 busy=1",
                     redirect_valid, flush, redirect_pc, trap_valid, busy, e.flush, e.rpc);
        end
        set_ev(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({redirect_valid, flush, busy} !== {1'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_release_idle got rv=%b flush=%b busy=%b want 0 0000 0",
                     redirect_valid, flush, busy);
        end
    endtask

    task automatic test_events();
        case_t cs[10];
        exp_t  e;
        cs[0] = '{4'b0100, 3'b000, 1'b0, 1'b0, 1'b0, 0, '{4'b0111, 32'h80,   1'b1, 6'h02, 32'h100}};
        cs[1] = '{4'b1000, 3'b110, 1'b1, 1'b0, 1'b0, 1, '{4'b1111, 32'h80,   1'b1, 6'h2B, 32'h400}};
        cs[2] = '{4'b1001, 3'b001, 1'b0, 1'b0, 1'b0, 0, '{4'b1111, 32'h80,   1'b1, 6'h05, 32'h400}};
        cs[3] = '{4'b0000, 3'b011, 1'b1, 1'b0, 1'b0, 2, '{4'b1111, 32'h80,   1'b1, 6'h27, 32'h400}};
        cs[4] = '{4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 3, '{4'b0111, 32'h2000, 1'b0, 6'h00, 32'h0}};
        cs[5] = '{4'b0001, 3'b000, 1'b0, 1'b0, 1'b1, 0, '{4'b0001, 32'h80,   1'b1, 6'h04, 32'h10}};
        cs[6] = '{4'b0000, 3'b000, 1'b0, 1'b0, 1'b1, 0, '{4'b0011, 32'h3000, 1'b0, 6'h00, 32'h0}};
        cs[7] = '{4'b0000, 3'b000, 1'b0, 1'b1, 1'b1, 1, '{4'b0111, 32'h2000, 1'b0, 6'h00, 32'h0}};
        cs[8] = '{4'b0010, 3'b000, 1'b0, 1'b1, 1'b0, 0, '{4'b0011, 32'h80,   1'b1, 6'h07, 32'h20}};
        cs[9] = '{4'b0000, 3'b001, 1'b1, 1'b0, 1'b1, 0, '{4'b1111, 32'h80,   1'b1, 6'h23, 32'h400}};
        foreach (cs[n]) begin
            set_ev(cs[n].exc, cs[n].irq, cs[n].en, cs[n].mis, cs[n].mret);
            push_exp(cs[n].exp, cs[n].mis & ~cs[n].exp.trap);
            @(negedge clk);
            set_ev(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if ({redirect_valid, flush, redirect_pc, trap_valid, busy} !== {1'b1, e.flush, e.rpc, e.trap, 1'b1}) begin
                errors++;
                $display("FAIL event_resp case %0d got rv=%b flush=%b rpc=%h tv=%b busy=%b want rv=1 flush=%b rpc=%h tv=%b busy=1",
                         n, redirect_valid, flush, redirect_pc, trap_valid, busy, e.flush, e.rpc, e.trap);
            end
            if (e.trap) begin
                checks++;
                if ({trap_cause, trap_pc} !== {e.cause, e.tpc}) begin
                    errors++;
                    $display("FAIL event_trap case %0d got cause=%h tpc=%h want cause=%h tpc=%h",
                             n, trap_cause, trap_pc, e.cause, e.tpc);
                end
            end
            redirect_ready = (cs[n].delay == 0);
            for (int d = 1; d <= cs[n].delay; d++) begin
                @(negedge clk);
                checks++;
                if ({redirect_valid, flush, redirect_pc, trap_valid} !== {1'b1, e.flush, e.rpc, 1'b0}) begin
                    errors++;
                    $display("FAIL event_hold case %0d cycle %0d got rv=%b flush=%b rpc=%h tv=%b want rv=1 flush=%b rpc=%h tv=0",
                             n, d, redirect_valid, flush, redirect_pc, trap_valid, e.flush, e.rpc);
                end
                if (d == cs[n].delay) redirect_ready = 1'b1;
            end
            @(negedge clk);
            redirect_ready = 1'b0;
            checks++;
            if ({redirect_valid, flush, trap_valid, busy} !== {1'b0, e.flush, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL event_drain case %0d got rv=%b flush=%b tv=%b busy=%b want rv=0 flush=%b tv=0 busy=1",
                         n, redirect_valid, flush, trap_valid, busy, e.flush);
            end
            @(negedge clk);
            checks++;
            if ({redirect_valid, flush, trap_valid, busy} !== 7'b0) begin
                errors++;
                $display("FAIL event_idle case %0d got rv=%b flush=%b tv=%b busy=%b want all 0",
                         n, redirect_valid, flush, trap_valid, busy);
            end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        set_ev(4'b0000, 3'b000, 1'b0, 1'b1, 1'b0);
        push_exp('{4'b0111, 32'h2000, 1'b0, 6'h00, 32'h0}, 1'b1);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({redirect_valid, flush, redirect_pc} !== {1'b1, e.flush, e.rpc}) begin
            errors++;
            $display("FAIL busy_resp got rv=%b flush=%b rpc=%h want rv=1 flush=%b rpc=%h",
                     redirect_valid, flush, redirect_pc, e.flush, e.rpc);
        end
        // Higher-priority events arriving while busy must not disturb the redirect
        set_ev(4'b1000, 3'b100, 1'b1, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({redirect_valid, flush, redirect_pc, trap_valid} !== {1'b1, e.flush, e.rpc, 1'b0}) begin
                errors++;
                $display("FAIL busy_hold got rv=%b flush=%b rpc=%h tv=%b want rv=1 flush=%b rpc=%h tv=0",
                         redirect_valid, flush, redirect_pc, trap_valid, e.flush, e.rpc);
            end
        end
        set_ev(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({redirect_valid, flush, trap_valid, busy} !== 7'b0) begin
            errors++;
            $display("FAIL busy_after got rv=%b flush=%b tv=%b busy=%b want all 0",
                     redirect_valid, flush, trap_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        set_ev(4'b0000, 3'b000, 1'b0, 1'b1, 1'b0);
        redirect_ready = 1'b1;
        push_exp('{4'b0111, 32'h2000, 1'b0, 6'h00, 32'h0}, 1'b1);
        push_exp('{4'b0111, 32'h2000, 1'b0, 6'h00, 32'h0}, 1'b1);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({redirect_valid, flush, redirect_pc, busy} !== {1'b1, e.flush, e.rpc, 1'b1}) begin
                errors++;
                $display("FAIL b2b_resp %0d got rv=%b flush=%b rpc=%h busy=%b want rv=1 flush=%b rpc=%h busy=1",
                         r, redirect_valid, flush, redirect_pc, busy, e.flush, e.rpc);
            end
            if (r == 1) set_ev(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if ({redirect_valid, flush, busy} !== {1'b0, e.flush, 1'b1}) begin
                errors++;
                $display("FAIL b2b_drain %0d got rv=%b flush=%b busy=%b want rv=0 flush=%b busy=1",
                         r, redirect_valid, flush, busy, e.flush);
            end
            @(negedge clk);
            checks++;
            if ({redirect_valid, flush, busy} !== 6'b0) begin
                errors++;
                $display("FAIL b2b_idle %0d got rv=%b flush=%b busy=%b want all 0",
                         r, redirect_valid, flush, busy);
            end
        end
        redirect_ready = 1'b0;
    endtask

    task automatic test_perf();
`ifdef PIPE_FLUSH_PERF_CNT_EN
        checks++;
        if ({perf_trap_cnt, perf_mispred_cnt} !== {32'(exp_traps), 32'(exp_mis)}) begin
            errors++;
            $display("FAIL perf_counts got traps=%0d mispred=%0d want traps=%0d mispred=%0d",
                     perf_trap_cnt, perf_mispred_cnt, exp_traps, exp_mis);
        end
`endif
    endtask

    task automatic test_reset_mid_redirect();
        exp_t e;
        set_ev(4'b0100, 3'b000, 1'b0, 1'b0, 1'b0);
        push_exp('{4'b0111, 32'h80, 1'b1, 6'h02, 32'h100}, 1'b0);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({redirect_valid, flush, redirect_pc, trap_valid} !== {1'b1, e.flush, e.rpc, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_resp got rv=%b flush=%b rpc=%h tv=%b want rv=1 flush=%b rpc=%h tv=1",
                     redirect_valid, flush, redirect_pc, trap_valid, e.flush, e.rpc);
        end
        set_ev(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        exp_traps = 0;
        exp_mis   = 0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({flush, redirect_valid, redirect_pc, trap_valid, trap_cause, trap_pc, busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_zero got flush=%b rv=%b rpc=%h tv=%b cause=%h tpc=%h busy=%b want all 0",
                     flush, redirect_valid, redirect_pc, trap_valid, trap_cause, trap_pc, busy);
        end
        set_ev(4'b0000, 3'b000, 1'b0, 1'b0, 1'b1);
        push_exp('{4'b0011, 32'h3000, 1'b0, 6'h00, 32'h0}, 1'b0);
        @(negedge clk);
        set_ev(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front();
        checks++;
        if ({redirect_valid, flush, redirect_pc, trap_valid, busy} !== {1'b1, e.flush, e.rpc, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_next got rv=%b flush=%b rpc=%h tv=%b busy=%b want rv=1 flush=%b rpc=%h tv=0 busy=1",
                     redirect_valid, flush, redirect_pc, trap_valid, busy, e.flush, e.rpc);
        end
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({redirect_valid, flush, busy} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_idle got rv=%b flush=%b busy=%b want all 0", redirect_valid, flush, busy);
        end
    endtask

    initial begin
        test_reset();
        test_events();
        test_busy_ignore();
        test_back_to_back();
        test_perf();
        test_reset_mid_redirect();
        test_perf();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_flush_ctrl.md
PIPE_FLUSH_CTRL -- requirements
Module: pipe_flush_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of flushable pipeline stages; stage 0 is youngest (IF) and NUM_STAGES-1 is oldest (EX).
REQ-002 SHALL have parameter XLEN, default 32, PC width.
REQ-003 SHALL have parameter NIRQ, default 3, interrupt line count; index 0 is soft, 1 is timer, 2 is external.
REQ-004 SHALL have parameter MRET_STAGE, default 1, stage index at which mret is decoded.
REQ-005 SHALL have parameter FLUSH_HOLD, default 1, extra cycles flush_o stays asserted after redirect acceptance; range 0..15.
REQ-006 SHALL have ports: clk_i  in  1  clock (one clock domain); rst_i  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: stage_exc_valid_i  in  NUM_STAGES  per-stage exception request; stage_cause_i  in  NUM_STAGES*5  per-stage exception cause; stage_pc_i  in  NUM_STAGES*XLEN  per-stage PC.
REQ-008 SHALL have ports: mret_i  in  1  mret at MRET_STAGE; mepc_i  in  XLEN  return address; mtvec_i  in  XLEN  trap vector.
REQ-009 SHALL have ports: mispredict_i  in  1  branch resolved wrong at oldest stage; mispredict_target_i  in  XLEN  correct target.
REQ-010 SHALL have ports: irq_i  in  NIRQ  pending level interrupts; irq_en_i  in  1  global interrupt enable (mstatus.MIE).
REQ-011 SHALL have ports: flush_o  out  NUM_STAGES  bit k flushes stage k; redirect_valid_o  out  1 and redirect_pc_o  out  XLEN, the fetch redirect; redirect_ready_i  in  1  fetch accepts redirect.
REQ-012 SHALL have ports: trap_valid_o  out  1  one-cycle pulse to the CSR file; trap_cause_o  out  6  {interrupt bit, code[4:0]}; trap_pc_o  out  XLEN  value for mepc; busy_o  out  1  controller not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, REDIRECT and DRAIN; events SHALL be sampled only in IDLE and ignored otherwise (upstream stalls on busy_o).
REQ-014 IDLE event priority SHALL be: interrupt (irq_en_i and any irq_i), then exception at the oldest valid stage, then mispredict_i, then mret_i.
REQ-015 An exception at stage k SHALL beat an mret at the same stage or at a younger stage.
REQ-016 Interrupt handling SHALL use the highest set irq index i: cause {1, 4*i+3}, trap_pc = stage_pc[NUM_STAGES-1], all flush bits set, redirect to mtvec_i.
REQ-017 Exception handling at stage k SHALL give cause {0, stage_cause[k]}, trap_pc = stage_pc[k], flush bits 0..k set, redirect to mtvec_i.
REQ-018 Mispredict handling SHALL set flush bits 0..NUM_STAGES-2, redirect to mispredict_target_i, and produce no trap_valid_o.
REQ-019 Mret handling SHALL set flush bits 0..MRET_STAGE, redirect to mepc_i, and produce no trap_valid_o.
REQ-020 Latency: an event sampled in cycle N SHALL give registered flush_o, redirect_valid_o and redirect_pc_o in cycle N+1, trap_valid_o pulsing in N+1 only, and the FSM entering REDIRECT.
REQ-021 In REDIRECT, redirect_valid_o, redirect_pc_o and flush_o SHALL hold stable until redirect_ready_i is high; a handshake cycle deasserts redirect_valid_o next cycle.
REQ-022 After the handshake, the FSM SHALL enter DRAIN and hold flush_o for FLUSH_HOLD cycles via a down-counter, then return to IDLE with flush_o cleared; FLUSH_HOLD=0 SHALL go directly to IDLE.
REQ-023 Ready high in the same cycle redirect_valid_o first asserts SHALL count as a handshake (minimum one-cycle REDIRECT).
REQ-024 busy_o SHALL equal (state != IDLE), registered.

Reset
REQ-025 With rst_i high at a clock edge, the state SHALL go to IDLE and all outputs to 0 next cycle, including mid-REDIRECT or mid-DRAIN; a pending redirect is dropped.
REQ-026 Events present during reset SHALL be ignored; sampling resumes in the first cycle rst_i is low.

Configuration
REQ-027 Macro PIPE_FLUSH_PERF_CNT_EN defined SHALL add outputs perf_trap_cnt_o and perf_mispred_cnt_o (32-bit, wrapping, reset 0), incremented once per accepted trap and per accepted mispredict respectively.
REQ-028 With PIPE_FLUSH_PERF_CNT_EN undefined, those ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-029 stage_exc_valid_i=4'b0100, cause 2, pc[2]=0x100, mtvec=0x80 -> next cycle flush_o=4'b0111, trap_cause=0x02, trap_pc=0x100, redirect_pc=0x80.
REQ-030 irq_i=3'b110, irq_en_i=1, stage_exc_valid_i=4'b1000 in the same cycle -> interrupt wins: cause 0x2B, flush_o=4'b1111.
REQ-031 mispredict_i=1, target 0x2000, redirect_ready_i low for 3 cycles -> redirect and flush_o=4'b0111 held stable for 4 cycles, then 1 DRAIN cycle, then IDLE; trap_valid_o never high.
REQ-032 mret_i=1 with stage_exc_valid_i=4'b0001 -> exception wins, flush_o=4'b0001, redirect to mtvec.
REQ-033 rst_i asserted during REDIRECT -> all outputs 0 next cycle; a later event is handled normally.
REQ-034 Counters enabled, 3 traps and 2 mispredicts -> perf_trap_cnt_o=3, perf_mispred_cnt_o=2; events arriving while busy are not counted.
